// File: rtl/apb_mst_bridge.sv
// Single-outstanding APB initiator: valid/ready request/response in, APB2/APB3 transfers out.
// Optional wait-state abort is compiled in with `define APB_MST_TIMEOUT_EN.
module apb_mst_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              sys_clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mst_apb_psel,
  output logic              mst_apb_penable,
  output logic              mst_apb_pwrite,
  output logic [ADDR_W-1:0] mst_apb_paddr,
  output logic [DATA_W-1:0] mst_apb_pwdata,
  input  logic [DATA_W-1:0] apb_mst_prdata,
  input  logic              apb_mst_pready,
  output logic [1:0]        dbg_state
);

  // Handshakes: a request transfers on an edge where req_valid && req_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready. Response
  // fields never change while rsp_valid is high and rsp_ready is low.

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_mst_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef APB_MST_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`endif

  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge sys_clk) begin
    if (!rst_b) begin
      state           <= IDLE;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      mst_apb_psel    <= 1'b0;
      mst_apb_penable <= 1'b0;
      mst_apb_pwrite  <= 1'b0;
      mst_apb_paddr   <= '0;
      mst_apb_pwdata  <= '0;
`ifdef APB_MST_TIMEOUT_EN
      wait_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_write <= req_write;
            // Misaligned requests are answered locally without touching the bus.
            if (req_addr[1:0] != 2'b00) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state           <= SETUP;
              mst_apb_psel    <= 1'b1;
              mst_apb_penable <= 1'b0;
              mst_apb_pwrite  <= req_write;
              mst_apb_paddr   <= req_addr;
              mst_apb_pwdata  <= req_wdata;
            end
          end
        end
        SETUP: begin
          state           <= ACCESS;
          mst_apb_penable <= 1'b1;
`ifdef APB_MST_TIMEOUT_EN
          wait_cnt        <= '0;
`endif
        end
        ACCESS: begin
          if (apb_mst_pready) begin
            state           <= RESP;
            mst_apb_psel    <= 1'b0;
            mst_apb_penable <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_err         <= 1'b0;
            rsp_rdata       <= mst_apb_pwrite ? '0 : apb_mst_prdata;
          end
`ifdef APB_MST_TIMEOUT_EN
          else if (wait_cnt == TMO_LAST) begin
            state           <= RESP;
            mst_apb_psel    <= 1'b0;
            mst_apb_penable <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_err         <= 1'b1;
            rsp_rdata       <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Bench for apb_mst_bridge: directed plan steps plus random transfers against a
// word-array reference model and a small APB slave memory.
module tb_apb_mst_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 4;

  logic          sys_clk;
  logic          rst_b;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] ref_mem[16];
  logic [DW-1:0] sl_mem[16];

  apb_mst_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk(sys_clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mst_apb_psel(psel), .mst_apb_penable(penable), .mst_apb_pwrite(pwrite),
    .mst_apb_paddr(paddr), .mst_apb_pwdata(pwdata),
    .apb_mst_prdata(prdata), .apb_mst_pready(pready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // APB slave: word memory, each word initially {index, index}
  assign prdata = sl_mem[paddr[5:2]];
  always @(posedge sys_clk) begin
    if (psel && penable && pready && pwrite) sl_mem[paddr[5:2]] <= pwdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Full request/response transaction; called at a negedge with the DUT idle.
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input int hold);
    logic [DW+1:0] exp;
    logic mis;
    mis = (a[1:0] != 2'b00);
    if (mis)    exp = {1'b1, w, {DW{1'b0}}};
    else if (w) begin exp = {1'b0, 1'b1, {DW{1'b0}}}; ref_mem[a[5:2]] = d; end
    else        exp = {1'b0, 1'b0, ref_mem[a[5:2]]};
    exp_q.push_back(exp);

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    rsp_ready = 1'b0; pready = 1'b0;
    tick();
    // garbage requests while busy must be ignored
    req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    check("req_ready_busy", req_ready, 0);
    if (mis) begin
      check("mis_no_psel", psel, 0);
    end else begin
      check("setup_psel", psel, 1);
      check("setup_penable", penable, 0);
      check("setup_rsp_valid", rsp_valid, 0);
      check("setup_paddr", paddr, a);
      check("setup_pwrite", pwrite, w);
      if (w) check("setup_pwdata", pwdata, d);
      tick();
      for (int c = 0; c <= waits; c++) begin
        check("access_psel", psel, 1);
        check("access_penable", penable, 1);
        check("access_paddr", paddr, a);
        check("access_pwrite", pwrite, w);
        if (w) check("access_pwdata", pwdata, d);
        check("access_rsp_valid", rsp_valid, 0);
        pready = (c == waits);
        tick();
      end
      pready = 1'b0;
      check("done_psel", psel, 0);
      check("done_penable", penable, 0);
    end
    check("rsp_valid", rsp_valid, 1);
    exp = exp_q.pop_front();
    check("rsp_fields", {rsp_err, rsp_write, rsp_rdata}, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_fields", {rsp_err, rsp_write, rsp_rdata}, exp);
      check("hold_req_ready", req_ready, 0);
      check("hold_psel", psel, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
    check("post_psel", psel, 0);
    if (!mis) check("post_paddr_kept", paddr, a);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = {16'(i), 16'(i)};
      sl_mem[i]  = {16'(i), 16'(i)};
    end
    rst_b = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_b = 1'b1;

    // reset values
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_write", rsp_write, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);

    // directed plan steps
    do_req(1'b0, 32'h04, 32'h0, 0, 0);
    do_req(1'b1, 32'h08, 32'hDEADBEEF, 0, 0);
    do_req(1'b0, 32'h08, 32'h0, 0, 0);
    do_req(1'b0, 32'h1C, 32'h0, 3, 0);
    do_req(1'b0, 32'h06, 32'h0, 0, 5);
    do_req(1'b1, 32'h13, 32'h12345678, 0, 2);

    // reset during ACCESS drops the transfer
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    tick();
    req_valid = 1'b0;
    tick();
    check("rstmid_in_access", penable, 1);
    pready = 1'b0; rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    check("rstmid_psel", psel, 0);
    check("rstmid_penable", penable, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_req_ready", req_ready, 1);
    tick();
    check("rstmid_no_rsp", rsp_valid, 0);
    do_req(1'b0, 32'h10, 32'h0, 1, 1);

`ifdef APB_MST_TIMEOUT_EN
    // stuck slave aborts after TMO wait cycles
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0C; pready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    for (int c = 0; c < TMO; c++) begin
      check("tmo_penable", penable, 1);
      check("tmo_rsp_valid", rsp_valid, 0);
      tick();
    end
    check("tmo_psel", psel, 0);
    check("tmo_rsp_valid_set", rsp_valid, 1);
    check("tmo_rsp_err", rsp_err, 1);
    check("tmo_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h00, 32'h0, 0, 0);
`endif

    // random traffic
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = {26'b0, 6'($urandom_range(0, 63))};
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_req(1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_mst_bridge.md
Name: apb_mst_bridge

Overview:
- Single-outstanding APB initiator. Converts a simple valid/ready request/response interface into APB2/APB3 read and write transfers.
- Sits between an internal master (debug loader, DMA-lite, test sequencer) and APB slaves such as the SFR register bank.
- Drives psel/penable/pwrite/paddr/pwdata and samples prdata, with optional pready wait states.
- Returns read data or an error flag on the response channel.

Parameters:
ADDR_W, 32, width of request address and paddr
DATA_W, 32, width of wdata/rdata/pwdata/prdata
TIMEOUT_CYCLES, 16, consecutive pready-low ACCESS cycles before abort (used only with the optional feature); legal range 1..255

Ports:
sys_clk  input  1  clock; all logic rising-edge
rst_b  input  1  reset, synchronous, active-low
req_valid  input  1  request present
req_ready  output  1  bridge can accept a request this cycle
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_write  output  1  echo of the request's req_write
rsp_rdata  output  DATA_W  read data; 0 for writes and errors
rsp_err  output  1  1=misaligned request or timeout
mst_apb_psel  output  1  APB select
mst_apb_penable  output  1  APB enable
mst_apb_pwrite  output  1  APB direction
mst_apb_paddr  output  ADDR_W  APB address
mst_apb_pwdata  output  DATA_W  APB write data
apb_mst_prdata  input  DATA_W  APB read data
apb_mst_pready  input  1  slave ready; tie 1 for zero-wait slaves

Behaviour:
- Interface: one clock (sys_clk); reset rst_b is synchronous and active-low. While rst_b is 0 at a rising edge, all state returns to reset on that edge.
- Reset values:
  - State = IDLE.
  - req_ready = 1 (combinational from IDLE state).
  - rsp_valid, rsp_write, rsp_err = 0; rsp_rdata = 0.
  - psel, penable, pwrite = 0; paddr = 0; pwdata = 0.
- All APB and rsp outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1; req_ready is 0 in all other states.
  - On req_valid && req_ready, latch write, addr and wdata.
  - If req_addr[1:0] != 0: go to RESP with rsp_err=1, rsp_rdata=0. No APB activity.
  - Otherwise: go to SETUP. In the same edge, load psel=1, penable=0, pwrite, paddr and pwdata.
- SETUP (one cycle): next edge loads penable=1 and goes to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite and pwdata are held stable.
  - If pready=1: clear psel and penable, go to RESP, assert rsp_valid.
    - Reads: rsp_rdata = prdata sampled on this edge.
    - Writes: rsp_rdata = 0.
    - rsp_err = 0.
  - If pready=0: remain in ACCESS.
- RESP:
  - rsp_valid=1; rsp_write, rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready: clear rsp_valid and go to IDLE.
- paddr, pwdata and pwrite keep their last values after a transfer. They change only when a new request is accepted.
- Latency, zero-wait slave with rsp_ready held at 1:
  - Accept at edge 0, SETUP visible cycle 1, ACCESS cycle 2, rsp_valid cycle 3, IDLE cycle 4.
  - Minimum spacing is 4 cycles per transfer.
  - Misaligned request: rsp_valid is visible the cycle after acceptance.
- Simultaneous events: req_valid is ignored outside IDLE. No buffering; a single transaction is outstanding at any time.
- Reset mid-transfer: psel and penable drop at the reset edge and no response is issued. The in-flight request is lost, and the requester must reissue it.
- Without the timeout feature, a slave that holds pready low keeps the bridge in ACCESS indefinitely.

Optional Feature:
- Macro: APB_MST_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS.
  - It increments on each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYCLES while pready is still 0:
    - Next edge clears psel and penable and goes to RESP.
    - rsp_err=1, rsp_rdata=0.
  - If pready=1 on the same cycle the counter would expire, the normal completion takes priority.
- Not defined: the counter is absent, there is no abort path, and rsp_err is set only for misaligned requests.

Test Plan:
- SFR bank attached, pready tied 1. Read 0x04 → exactly one SETUP cycle then one ACCESS cycle; rsp_rdata=0x00010001, rsp_err=0, rsp_valid on cycle 3 after accept.
- Write 0x08 data 0xDEADBEEF, then read 0x08 → pwrite=1 with pwdata=0xDEADBEEF during ACCESS; read returns 0xDEADBEEF; the write response has rsp_rdata=0, rsp_write=1.
- pready low for 3 ACCESS cycles on a read of 0x1C → penable high for 4 cycles with paddr stable; rsp_rdata=0x00070007 sampled on the pready=1 edge.
- req_addr=0x06 → psel never asserts; rsp_valid the next cycle with rsp_err=1, rsp_rdata=0. With rsp_ready held 0 for 5 cycles, response fields stay stable and req_ready stays 0.
- APB_MST_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, pready stuck 0 → abort after 4 wait cycles; rsp_err=1 and psel=0. A following read of 0x00 with pready=1 returns 0x00000000, rsp_err=0.
- rst_b driven 0 during ACCESS for one edge → psel and penable are 0 the next cycle, no rsp_valid, req_ready=1 once rst_b=1; a new request completes normally.
